// File: rtl/frame_draw_sched.sv
// Frame draw scheduler: grants the frame-buffer write port to up to four graphing
// units in fixed priority order once per frame tick, with a per-grant timeout.
module frame_draw_sched #(
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic [3:0]  req,
  input  logic [3:0]  done_in,
  input  logic [35:0] x_bus,
  input  logic [31:0] y_bus,
  input  logic [11:0] colour_bus,
  input  logic [3:0]  we_bus,
  output logic [3:0]  plot_out,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_we,
  output logic        busy,
  output logic [7:0]  frame_count,
  output logic        overrun,
  output logic [3:0]  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SELECT,
    S_START,
    S_WAIT,
    S_FRAME_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        overrun_q, overrun_d;
  logic [3:0]  timeout_err_q, timeout_err_d;
  logic        granted;

  logic [8:0] x_arr [4];
  logic [7:0] y_arr [4];
  logic [2:0] c_arr [4];

  for (genvar i = 0; i < 4; i++) begin : g_slice
    assign x_arr[i] = x_bus[9*i +: 9];
    assign y_arr[i] = y_bus[8*i +: 8];
    assign c_arr[i] = colour_bus[3*i +: 3];
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch only; no
  // resetn in the sensitivity list. Sequential state uses non-blocking (<=).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    plot_out      = '0;
    granted       = 1'b0;

    // A tick outside IDLE is dropped, but remembered as an overrun.
    if (frame_tick && state_q != S_IDLE) overrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: if (frame_tick) state_d = S_LATCH;
      S_LATCH: begin
        pending_d = req;
        state_d   = S_SELECT;
      end
      S_SELECT: begin
        if (pending_q == 4'b0000) begin
          state_d = S_FRAME_DONE;
        end else begin
          if      (pending_q[0]) sel_d = 2'd0;
          else if (pending_q[1]) sel_d = 2'd1;
          else if (pending_q[2]) sel_d = 2'd2;
          else                   sel_d = 2'd3;
          state_d = S_START;
        end
      end
      S_START: begin
        granted          = 1'b1;
        plot_out[sel_q]  = 1'b1;
        cnt_d            = '0;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        granted = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        // A completion on the final allowed cycle wins over the timeout.
        if (done_in[sel_q]) begin
          pending_d[sel_q] = 1'b0;
          state_d          = S_SELECT;
        end else if (cnt_d == TIMEOUT) begin
          timeout_err_d[sel_q] = 1'b1;
          pending_d[sel_q]     = 1'b0;
          state_d              = S_SELECT;
        end
      end
      S_FRAME_DONE: begin
        frame_count_d = frame_count_q + 8'd1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vga_x       = granted ? x_arr[sel_q]  : '0;
  assign vga_y       = granted ? y_arr[sel_q]  : '0;
  assign vga_colour  = granted ? c_arr[sel_q]  : '0;
  assign vga_we      = granted & we_bus[sel_q];
  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
